// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM encoding and port ids.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Port identifiers used for grants and the last-granted record.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of instruction, data and shared-memory port signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both request ports; responses are single-cycle pulses.
interface mem_arbiter_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int LINE_SIZE    = 128
);
    logic                    ireq_valid;
    logic [ADDRESS_SIZE-1:0] ireq_addr;
    logic                    ireq_ready;
    logic                    iresp_valid;
    logic [LINE_SIZE-1:0]    iresp_data;

    logic                    dreq_valid;
    logic                    dreq_write;
    logic [ADDRESS_SIZE-1:0] dreq_addr;
    logic [LINE_SIZE-1:0]    dreq_wdata;
    logic                    dreq_ready;
    logic                    dresp_valid;
    logic [LINE_SIZE-1:0]    dresp_data;

    logic                    mem_req;
    logic                    mem_write;
    logic [ADDRESS_SIZE-1:0] mem_addr;
    logic [LINE_SIZE-1:0]    mem_wdata;
    logic [LINE_SIZE-1:0]    mem_rdata;

    // Arbiter side.
    modport slave (
        input  ireq_valid, ireq_addr,
        input  dreq_valid, dreq_write, dreq_addr, dreq_wdata,
        input  mem_rdata,
        output ireq_ready, iresp_valid, iresp_data,
        output dreq_ready, dresp_valid, dresp_data,
        output mem_req, mem_write, mem_addr, mem_wdata
    );

    // Requester / memory side.
    modport master (
        output ireq_valid, ireq_addr,
        output dreq_valid, dreq_write, dreq_addr, dreq_wdata,
        output mem_rdata,
        input  ireq_ready, iresp_valid, iresp_data,
        input  dreq_ready, dresp_valid, dresp_data,
        input  mem_req, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin selector between instruction and data request lines.
// Latency: combinational, zero cycles.
// Backpressure: none; grant is only meaningful when grant_vld is high.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_vld,
    output logic grant_port
);

    // A lone requester always wins; on a tie the port not granted last wins.
    always_comb begin
        grant_vld  = req_i | req_d;
        grant_port = PORT_I;
        if (req_i && req_d) begin
            grant_port = (last_grant == PORT_D) ? PORT_I : PORT_D;
        end else if (req_d) begin
            grant_port = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction and data requesters, one access in flight.
// Latency: accept at T, mem_req T+1..T+MEM_LATENCY, response pulse at T+MEM_LATENCY+1.
// Backpressure: ready only in IDLE; requesters hold valid/payload until ready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDRESS_SIZE = 32,
    parameter int LINE_SIZE    = 128,
    parameter int MEM_LATENCY  = 5
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int OFS_W = $clog2(LINE_SIZE / 8);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
    // Byte-offset bits within a line; cleared so the memory sees line-aligned addresses.
    localparam logic [ADDRESS_SIZE-1:0] OFS_MASK = ADDRESS_SIZE'((64'd1 << OFS_W) - 64'd1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sel_q, sel_d;
    logic                    last_q, last_d;
    logic                    write_q, write_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [LINE_SIZE-1:0]    wdata_q, wdata_d;
    logic [LINE_SIZE-1:0]    rdata_q, rdata_d;

    logic gnt_vld;
    logic gnt_port;

    rr_arbiter2 u_rr (
        .req_i      (bus.ireq_valid),
        .req_d      (bus.dreq_valid),
        .last_grant (last_q),
        .grant_vld  (gnt_vld),
        .grant_port (gnt_port)
    );

    // Next-state: latch the winner's access in IDLE, count down in BUSY, retire in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    sel_d   = gnt_port;
                    cnt_d   = CNT_INIT;
                    state_d = ST_BUSY;
                    if (gnt_port == PORT_I) begin
                        addr_d  = bus.ireq_addr & ~OFS_MASK;
                        write_d = 1'b0;
                        wdata_d = '0;
                    end else begin
                        addr_d  = bus.dreq_addr & ~OFS_MASK;
                        write_d = bus.dreq_write;
                        wdata_d = bus.dreq_wdata;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                last_d  = sel_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Port outputs; ready and response pulses are suppressed while reset is held.
    always_comb begin
        bus.ireq_ready  = (state_q == ST_IDLE) && gnt_vld && (gnt_port == PORT_I) && !reset;
        bus.dreq_ready  = (state_q == ST_IDLE) && gnt_vld && (gnt_port == PORT_D) && !reset;
        bus.iresp_valid = (state_q == ST_RESP) && (sel_q == PORT_I) && !reset;
        bus.dresp_valid = (state_q == ST_RESP) && (sel_q == PORT_D) && !reset;
        bus.iresp_data  = bus.iresp_valid ? rdata_q : '0;
        bus.dresp_data  = (bus.dresp_valid && !write_q) ? rdata_q : '0;
        bus.mem_req     = (state_q == ST_BUSY);
        bus.mem_write   = (state_q == ST_BUSY) && write_q;
        bus.mem_addr    = addr_q;
        bus.mem_wdata   = wdata_q;
    end

    // State registers; reset aborts any access and gives the instruction port the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= PORT_I;
            last_q  <= PORT_D;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with expectation queues and a negedge monitor.
// Latency: n/a.
// Backpressure: drivers hold valid until ready is seen.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MEM_LATENCY = 5;

    typedef struct {
        logic [31:0]  addr;
        logic         write;
        logic [127:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic         port;
        logic [127:0] data;
    } resp_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   run_len = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];

    mem_arbiter_if #(.ADDRESS_SIZE(32), .LINE_SIZE(128)) ifc ();

    mem_arbiter #(.ADDRESS_SIZE(32), .LINE_SIZE(128), .MEM_LATENCY(MEM_LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) run_len <= ifc.mem_req ? run_len + 1 : 0;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a, ~a, a + 32'h1111_1111, 32'hCAFE_F00D};
    endfunction

    // Memory model: the line is only valid on the last busy cycle.
    assign ifc.mem_rdata = (ifc.mem_req && run_len == MEM_LATENCY - 1) ?
                           line_of(ifc.mem_addr) : 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_mem(input logic [31:0] addr, input logic wr, input logic [127:0] wd);
        mem_exp_t m;
        m.addr = addr; m.write = wr; m.wdata = wd;
        mem_q.push_back(m);
    endtask

    task automatic push_exp(input logic port, input logic [31:0] addr, input logic wr,
                            input logic [127:0] wd);
        resp_exp_t r;
        push_mem(addr, wr, wd);
        r.port = port;
        r.data = wr ? 128'h0 : line_of(addr);
        resp_q.push_back(r);
    endtask

    task automatic issue_i(input logic [31:0] a, input logic [31:0] post_addr);
        logic ok = 1'b0;
        @(posedge clk); #1;
        ifc.ireq_valid = 1'b1;
        ifc.ireq_addr  = a;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ifc.ireq_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        ifc.ireq_valid = 1'b0;
        ifc.ireq_addr  = post_addr;
        check("i_accept", 128'(ok), 128'(1));
    endtask

    task automatic issue_d(input logic wr, input logic [31:0] a, input logic [127:0] wd);
        logic ok = 1'b0;
        @(posedge clk); #1;
        ifc.dreq_valid = 1'b1;
        ifc.dreq_write = wr;
        ifc.dreq_addr  = a;
        ifc.dreq_wdata = wd;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ifc.dreq_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        ifc.dreq_valid = 1'b0;
        check("d_accept", 128'(ok), 128'(1));
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (mem_q.size() == 0 && resp_q.size() == 0 && !ifc.mem_req) break;
        end
        check("drain_mem_q", 128'(mem_q.size()), 128'(0));
        check("drain_resp_q", 128'(resp_q.size()), 128'(0));
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: handshake legality, memory-port contents/timing, response scoreboard.
    initial begin : monitor
        logic     prev_mem_req = 1'b0;
        logic     prev_reset   = 1'b0;
        logic     aborted      = 1'b0;
        int       acc_cyc      = -100;
        int       run_cnt      = 0;
        mem_exp_t cur;
        resp_exp_t r;
        cur.addr = '0; cur.write = 1'b0; cur.wdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_gate", 128'({ifc.ireq_ready, ifc.dreq_ready,
                                        ifc.iresp_valid, ifc.dresp_valid}), 128'(0));
                if (ifc.mem_req) aborted = 1'b1;
            end
            if (prev_reset) begin
                check("rst_next", 128'({ifc.mem_req, ifc.mem_write,
                                        ifc.iresp_valid, ifc.dresp_valid}), 128'(0));
            end
            if (reset && prev_reset) begin
                check("rst_outputs", 128'(|{ifc.mem_addr, ifc.mem_wdata,
                                           ifc.iresp_data, ifc.dresp_data}), 128'(0));
            end
            if (!reset && (ifc.ireq_ready || ifc.dreq_ready)) begin
                check("ready_idle", 128'({ifc.ireq_ready & ifc.dreq_ready, ifc.mem_req,
                                          ifc.iresp_valid, ifc.dresp_valid}), 128'(0));
                acc_cyc = cyc;
            end
            if (ifc.mem_req && !prev_mem_req) begin
                check("mem_start_cycle", 128'(cyc), 128'(acc_cyc + 1));
                if (mem_q.size() == 0) begin
                    check("mem_unexpected", 128'(1), 128'(0));
                end else begin
                    cur = mem_q.pop_front();
                    check("mem_addr", 128'(ifc.mem_addr), 128'(cur.addr));
                    check("mem_write", 128'(ifc.mem_write), 128'(cur.write));
                    check("mem_wdata", ifc.mem_wdata, cur.wdata);
                end
                run_cnt = 1;
            end else if (ifc.mem_req) begin
                run_cnt++;
                check("mem_hold", {ifc.mem_addr ^ cur.addr, 95'(0), ifc.mem_write ^ cur.write}
                                  | (ifc.mem_wdata ^ cur.wdata), 128'(0));
            end
            if (!ifc.mem_req && prev_mem_req) begin
                if (!aborted) check("mem_len", 128'(run_cnt), 128'(MEM_LATENCY));
                aborted = 1'b0;
            end
            if (ifc.iresp_valid || ifc.dresp_valid) begin
                check("resp_both", 128'(ifc.iresp_valid & ifc.dresp_valid), 128'(0));
                check("resp_cycle", 128'({prev_mem_req, ifc.mem_req}), 128'(2'b10));
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 128'(1), 128'(0));
                end else begin
                    r = resp_q.pop_front();
                    check("resp_port", 128'(ifc.dresp_valid ? PORT_D : PORT_I), 128'(r.port));
                    check("resp_data", ifc.dresp_valid ? ifc.dresp_data : ifc.iresp_data, r.data);
                end
            end
            prev_mem_req = ifc.mem_req;
            prev_reset   = reset;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        ifc.ireq_valid = 1'b1;
        ifc.ireq_addr  = 32'h0000_1234;
        ifc.dreq_valid = 1'b1;
        ifc.dreq_write = 1'b1;
        ifc.dreq_addr  = 32'h0000_5678;
        ifc.dreq_wdata = {4{32'h1357_9BDF}};
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ifc.ireq_valid = 1'b0;
        ifc.dreq_valid = 1'b0;
        ifc.dreq_write = 1'b0;
        reset = 1'b0;

        // Lone instruction read.
        push_exp(PORT_I, 32'h0000_1000, 1'b0, 128'h0);
        issue_i(32'h0000_1000, 32'h0000_1000);
        drain();

        // Simultaneous requests after reset: instruction first, address aligned.
        pulse_reset(2);
        push_exp(PORT_I, 32'h0000_1000, 1'b0, 128'h0);
        push_exp(PORT_D, 32'h0000_2010, 1'b0, 128'h0);
        fork
            issue_i(32'h0000_1004, 32'h0000_1004);
            issue_d(1'b0, 32'h0000_2010, 128'h0);
        join
        drain();

        // Continuous contention alternates I, D, I, D.
        push_exp(PORT_I, 32'h0000_1100, 1'b0, 128'h0);
        push_exp(PORT_D, 32'h0000_2100, 1'b0, 128'h0);
        push_exp(PORT_I, 32'h0000_1200, 1'b0, 128'h0);
        push_exp(PORT_D, 32'h0000_2200, 1'b0, 128'h0);
        fork
            begin
                issue_i(32'h0000_1100, 32'h0000_1100);
                issue_i(32'h0000_1200, 32'h0000_1200);
            end
            begin
                issue_d(1'b0, 32'h0000_2100, 128'h0);
                issue_d(1'b0, 32'h0000_2200, 128'h0);
            end
        join
        drain();

        // Data write-back: write enable and data held, zero response data.
        push_exp(PORT_D, 32'h0000_2000, 1'b1, {16{8'hA5}});
        issue_d(1'b1, 32'h0000_2000, {16{8'hA5}});
        ifc.dreq_write = 1'b0;
        drain();

        // Reset on the third busy cycle aborts the access; no response expected.
        push_mem(32'h0000_1300, 1'b0, 128'h0);
        issue_i(32'h0000_1300, 32'h0000_1300);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        push_exp(PORT_I, 32'h0000_1400, 1'b0, 128'h0);
        issue_i(32'h0000_1400, 32'h0000_1400);
        drain();

        // Address changes after acceptance must not disturb the latched access.
        push_exp(PORT_I, 32'h0000_1000, 1'b0, 128'h0);
        issue_i(32'h0000_1000, 32'h0000_1FF0);
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRESS_SIZE, 32, address width in bits.
REQ-002 Parameter LINE_SIZE, 128, width in bits of one memory line transfer.
REQ-003 Parameter MEM_LATENCY, 5, cycles the memory port is held per access (minimum 1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ireq_valid  input  1  instruction-side read request.
REQ-007 ireq_addr  input  ADDRESS_SIZE  instruction-side line address.
REQ-008 ireq_ready  output  1  instruction request accepted this cycle.
REQ-009 iresp_valid  output  1  instruction read data valid, one-cycle pulse.
REQ-010 iresp_data  output  LINE_SIZE  instruction read line.
REQ-011 dreq_valid  input  1  data-side request.
REQ-012 dreq_write  input  1  data-side request is a write-back (1) or read (0).
REQ-013 dreq_addr  input  ADDRESS_SIZE  data-side line address.
REQ-014 dreq_wdata  input  LINE_SIZE  data-side write line.
REQ-015 dreq_ready  output  1  data request accepted this cycle.
REQ-016 dresp_valid  output  1  data read data or write acknowledge, one-cycle pulse.
REQ-017 dresp_data  output  LINE_SIZE  data read line; zero for writes.
REQ-018 mem_req  output  1  shared memory port active.
REQ-019 mem_write  output  1  shared memory port write enable.
REQ-020 mem_addr  output  ADDRESS_SIZE  shared memory port address, line aligned.
REQ-021 mem_wdata  output  LINE_SIZE  shared memory port write line.
REQ-022 mem_rdata  input  LINE_SIZE  shared memory port read line, sampled on the last busy cycle.

Function
REQ-023 FSM states IDLE, BUSY, RESP; exactly one access in flight.
REQ-024 IDLE: if any request valid, select a winner, pulse its ready for one cycle, latch addr (low log2(LINE_SIZE/8) bits forced zero), write, wdata; next state BUSY, counter = MEM_LATENCY-1.
REQ-025 IDLE with no valid request: stay IDLE, no ready asserted.
REQ-026 Arbitration: single requester wins unconditionally; simultaneous requests go to the port not granted last (round-robin); after reset the instruction port has priority.
REQ-027 BUSY: mem_req=1 with latched address/write/wdata held stable; counter decrements each cycle; at counter==0 capture mem_rdata and go RESP.
REQ-028 RESP: pulse winner's resp_valid with captured data (dresp_data zero on writes); record winner as last-granted; next state IDLE.
REQ-029 Latency: request accepted in cycle T -> mem_req high cycles T+1..T+MEM_LATENCY -> resp_valid in cycle T+MEM_LATENCY+1; next acceptance no earlier than T+MEM_LATENCY+2.
REQ-030 ready is never asserted outside IDLE; requesters hold valid and payload stable until ready.
REQ-031 mem_write is never high for instruction-port accesses; mem_req, mem_write low outside BUSY.
REQ-032 Requests dropped before ready are ignored; request changes after acceptance do not affect the latched access.

Reset
REQ-033 reset forces IDLE, counter 0, last-granted = data port (so instruction wins first tie), all outputs 0.
REQ-034 reset during BUSY or RESP aborts the access: no resp_valid pulse, mem_req low the next cycle.

Structure
REQ-035 FSM state encoding and port-select constants (PORT_I, PORT_D) live in the shared processor package.
REQ-036 Round-robin selector is one sub-module, rr_arbiter2, purely combinational over two request lines plus last-granted.

Verification
REQ-037 ireq 0x1000 alone, MEM_LATENCY=5 -> ireq_ready at T, mem_req T+1..T+5, iresp_valid at T+6 with mem_rdata.
REQ-038 ireq 0x1004 and dreq read 0x2010 same cycle after reset -> instruction wins with mem_addr 0x1000, data wins next at 0x2010.
REQ-039 Both ports requesting continuously for 4 accesses -> grants alternate I,D,I,D.
REQ-040 dreq write 0x2000, wdata 0xA5..A5 -> mem_write=1, mem_wdata held 5 cycles, dresp_valid with dresp_data 0.
REQ-041 reset asserted at third BUSY cycle -> no resp pulse, mem_req 0 next cycle, next ireq accepted in IDLE normally.
REQ-042 ireq address changed to 0x1FF0 one cycle after acceptance -> mem_addr stays the latched value throughout BUSY.
